bp_fe_fetch_queue: RTL and testbench
====================================

// Module: bp_fe_fetch_queue
//
// PURPOSE
// - Buffers IF2 fetch packets (pc, instr, branch metadata, exception flag) from pc_gen/icache to the backend issue interface.
// - Decouples the frontend pipeline from backend stalls.
// - Supplies an almost-full hint, which pc_gen uses to stop launching new fetches before IF1/IF2 in-flight packets overflow.
// - Flushed on any redirect.
//
// PARAMETERS
// - bp_params_p          e_bp_default_cfg  proc config; supplies vaddr_width_p and branch_metadata_fwd_width_p
// - els_p                4                 queue depth; power of 2, >= 2
// - almost_full_slack_p  2                 almost_full_o asserts when free entries <= this value; range 1..els_p-1
//
// PORTS
// - clk_i                   in   1          clock
// - reset_i                 in   1          synchronous, active-high reset
// - flush_i                 in   1          redirect; discards all entries
// - enq_v_i                 in   1          enqueue valid
// - enq_ready_o             out  1          enqueue ready; transfer occurs when enq_v_i & enq_ready_o
// - enq_pc_i                in   vaddr      fetch pc
// - enq_instr_i             in   32         fetched instruction
// - enq_br_metadata_fwd_i   in   bmfw       branch metadata
// - enq_exception_v_i       in   1          fetch exception flag
// - deq_v_o                 out  1          head entry valid
// - deq_yumi_i              in   1          consumer accepts head; legal only when deq_v_o
// - deq_pc_o                out  vaddr      head fields
// - deq_instr_o             out  32         head fields
// - deq_br_metadata_fwd_o   out  bmfw       head fields
// - deq_exception_v_o       out  1          head fields
// - almost_full_o           out  1          free entries <= almost_full_slack_p
// - count_o                 out  clog2(els_p+1)  occupancy
//
// BEHAVIOUR
// - Reset: rd/wr ptrs = 0, count_o = 0, deq_v_o = 0, enq_ready_o = 1 in the first cycle after reset deasserts.
//   Storage is not reset; deq_* data is don't-care while deq_v_o = 0.
// - Pointers: $clog2(els_p)+1 bits; the MSB is the wrap bit.
//   empty when ptrs are equal; full when indices match and wrap bits differ.
//   Pointers wrap naturally from els_p-1 to 0.
// - enq_ready_o = ~full. It is registered-state-derived only: no combinational path from deq_yumi_i.
//   When full, simultaneous enq+deq is not allowed.
// - deq_v_o = ~empty (see the macro section for the bypass case).
// - Enqueue-to-dequeue latency is 1 cycle: the written entry is visible on deq_* in the next cycle.
// - Simultaneous enq & deq when neither full nor empty: both pointers advance; count unchanged.
// - flush_i has priority over everything:
//   - next cycle: ptrs equal, count_o = 0;
//   - any same-cycle enqueue is dropped;
//   - a same-cycle deq_yumi_i is still a legal transfer, but state is cleared regardless.
// - reset_i asserted mid-operation behaves as flush and additionally zeros ptrs.
// - almost_full_o = (els_p - count) <= almost_full_slack_p. It is registered-state-derived and stays 1 while full.
// - deq_yumi_i while deq_v_o = 0, or enq_v_i while ~enq_ready_o: assertion error in simulation; ignored in hardware.
//
// CONFIGURATION
// - Macro BP_FE_FETCH_QUEUE_BYPASS_EN.
// - Defined: when empty & enq_v_i & ~flush_i:
//   - deq_v_o = 1 and deq_* = enq_* combinationally, giving 0-cycle latency;
//   - if deq_yumi_i is also asserted that cycle, the packet is consumed and not written (ptrs unchanged).
// - Undefined: no enq->deq combinational path; minimum latency is 1 cycle.
// - count_o and almost_full_o are identical in both modes.
//
// STRUCTURE
// - bp_fe_pkg:
//   - typedef bp_fe_fetch_packet_s {pc, instr, br_metadata_fwd, exception_v}, declared via a width macro alongside the existing bp_fe structs;
//   - localparam fetch_instr_width_lp = 32.
// - Sub-module bp_fe_fetch_queue_ptr: wrap-bit pointer register with inc_i, clr_i, ptr_o; instantiated for rd and wr.
// - Storage: els_p x $bits(packet) register array, written on enqueue and read async at rd index.
//
// TESTING
// 1. Reset, then 1 enq of pc=0x8000_0000 -> next cycle deq_v_o=1, deq_pc_o=0x8000_0000, count_o=1.
// 2. els_p=4, 4 enqs with no yumi -> count_o=4, enq_ready_o=0, almost_full_o=1 (already 1 at count_o=2).
//    Then 4 yumis -> pcs in FIFO order, deq_v_o=0.
// 3. 10 back-to-back enq+deq after 1-entry prefill -> count_o stays 1; ptrs wrap twice; data order preserved.
// 4. 3 entries, then flush_i with enq_v_i=1 and pc=0x100 -> next cycle count_o=0, deq_v_o=0; 0x100 never appears.
// 5. reset_i pulsed with 2 entries queued -> next cycle count_o=0, enq_ready_o=1, deq_v_o=0.
// 6. BYPASS_EN, empty queue, enq pc=0x200 with deq_yumi_i=1 same cycle -> deq_pc_o=0x200 that cycle; next cycle count_o=0.
//    Without the macro: deq_v_o=0 that cycle, deq_pc_o=0x200 and deq_v_o=1 next cycle.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared frontend types and configuration helpers.
//
// Contents
//   bp_params_e                    processor configuration selector
//   fetch_instr_width_lp           width of a fetched instruction (32)
//   bp_vaddr_width()               virtual address width for a configuration
//   bp_br_metadata_fwd_width()     branch metadata width for a configuration
//   bp_fe_fetch_packet_width_m()   total bit width of a fetch packet
//   `DECLARE_BP_FE_FETCH_PACKET_S  declares bp_fe_fetch_packet_s locally
//   `DECLARE_BP_FE_PC_GEN_REDIRECT_S declares the pc_gen redirect struct
//
// The packet structs are declared by macro because their widths depend on
// the configuration. Each module expands the macro once with its own
// derived widths.

`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define DECLARE_BP_FE_FETCH_PACKET_S(vaddr_width_mp, bmfw_mp)          \
  typedef struct packed {                                               \
    logic [(vaddr_width_mp)-1:0]             pc;                        \
    logic [bp_fe_pkg::fetch_instr_width_lp-1:0] instr;                  \
    logic [(bmfw_mp)-1:0]                    br_metadata_fwd;           \
    logic                                    exception_v;               \
  } bp_fe_fetch_packet_s

`define DECLARE_BP_FE_PC_GEN_REDIRECT_S(vaddr_width_mp)                 \
  typedef struct packed {                                               \
    logic [(vaddr_width_mp)-1:0] npc;                                   \
    logic                        mispredict;                            \
  } bp_fe_pc_gen_redirect_s

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  localparam int fetch_instr_width_lp = 32;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_small_cfg: return 32;
      default:        return 39;
    endcase
  endfunction

  function automatic int bp_br_metadata_fwd_width(input bp_params_e cfg);
    case (cfg)
      e_bp_small_cfg: return 24;
      default:        return 36;
    endcase
  endfunction

  function automatic int bp_fe_fetch_packet_width_m(input int vaddr_width,
                                                    input int bmfw);
    return vaddr_width + fetch_instr_width_lp + bmfw + 1;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_fetch_queue_ptr.sv
// bp_fe_fetch_queue_ptr: wrap-bit pointer register for the fetch queue.
//
// The pointer carries one bit more than needed to index els_p entries; the
// extra MSB toggles each time the index wraps, which lets the parent tell
// full apart from empty when the two indices match.
//
// Ports
//   clk_i    in   1           clock
//   reset_i  in   1           synchronous active-high reset, zeros the pointer
//   inc_i    in   1           advance by one entry
//   clr_i    in   1           return to zero (flush); wins over inc_i
//   ptr_o    out  ptr_width   current pointer, {wrap, index}

module bp_fe_fetch_queue_ptr
  import bp_fe_pkg::*;
#(
  parameter  int els_p        = 4,
  localparam int ptr_width_lp = $clog2(els_p) + 1
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    inc_i,
  input  logic                    clr_i,
  output logic [ptr_width_lp-1:0] ptr_o
);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;

  // els_p is a power of two, so plain binary increment wraps the index from
  // els_p-1 to 0 and flips the wrap bit at the same time.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_fe_fetch_queue.sv
// bp_fe_fetch_queue: buffers IF2 fetch packets between pc_gen/icache and
// the backend issue interface, decoupling the frontend from backend stalls.
// Flushed on any redirect. almost_full_o lets pc_gen stop launching fetches
// early enough that packets already in IF1/IF2 still find room.
//
// Optional feature macro: BP_FE_FETCH_QUEUE_BYPASS_EN
//   Defined:   an enqueue into an empty queue appears on deq_* in the same
//              cycle; if it is also accepted that cycle it is never written.
//   Undefined: no enq->deq combinational path; minimum latency one cycle.
//
// Ports
//   clk_i                  in   1       clock
//   reset_i                in   1       synchronous active-high reset
//   flush_i                in   1       redirect; discards all entries
//   enq_v_i / enq_ready_o  in/out 1     enqueue handshake
//   enq_pc_i               in   vaddr   fetch pc
//   enq_instr_i            in   32      fetched instruction
//   enq_br_metadata_fwd_i  in   bmfw    branch metadata
//   enq_exception_v_i      in   1       fetch exception flag
//   deq_v_o / deq_yumi_i   out/in 1     dequeue handshake (valid-then-yumi)
//   deq_pc_o, deq_instr_o,
//   deq_br_metadata_fwd_o,
//   deq_exception_v_o      out  ...     head entry fields
//   almost_full_o          out  1       free entries <= almost_full_slack_p
//   count_o                out  clog2(els_p+1)  occupancy

module bp_fe_fetch_queue
  import bp_fe_pkg::*;
#(
  parameter  bp_params_e bp_params_p                 = e_bp_default_cfg,
  parameter  int         vaddr_width_p               = bp_vaddr_width(bp_params_p),
  parameter  int         branch_metadata_fwd_width_p = bp_br_metadata_fwd_width(bp_params_p),
  parameter  int         els_p                       = 4,
  parameter  int         almost_full_slack_p         = 2,
  localparam int         ptr_width_lp                = $clog2(els_p) + 1,
  localparam int         idx_width_lp                = $clog2(els_p),
  localparam int         count_width_lp              = $clog2(els_p + 1)
)(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   flush_i,

  input  logic                                   enq_v_i,
  output logic                                   enq_ready_o,
  input  logic [vaddr_width_p-1:0]               enq_pc_i,
  input  logic [fetch_instr_width_lp-1:0]        enq_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] enq_br_metadata_fwd_i,
  input  logic                                   enq_exception_v_i,

  output logic                                   deq_v_o,
  input  logic                                   deq_yumi_i,
  output logic [vaddr_width_p-1:0]               deq_pc_o,
  output logic [fetch_instr_width_lp-1:0]        deq_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] deq_br_metadata_fwd_o,
  output logic                                   deq_exception_v_o,

  output logic                                   almost_full_o,
  output logic [count_width_lp-1:0]              count_o
);

  `DECLARE_BP_FE_FETCH_PACKET_S(vaddr_width_p, branch_metadata_fwd_width_p);

  bp_fe_fetch_packet_s enq_pkt;
  bp_fe_fetch_packet_s head_pkt;
  bp_fe_fetch_packet_s deq_pkt;
  bp_fe_fetch_packet_s mem_q [els_p];

  logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
  logic [idx_width_lp-1:0] rd_idx, wr_idx;
  logic [ptr_width_lp-1:0] used_cnt;

  logic empty, full;
  logic bypass_v, bypass_consume;
  logic wr_inc, rd_inc;

  assign enq_pkt.pc              = enq_pc_i;
  assign enq_pkt.instr           = enq_instr_i;
  assign enq_pkt.br_metadata_fwd = enq_br_metadata_fwd_i;
  assign enq_pkt.exception_v     = enq_exception_v_i;

  assign rd_idx = rd_ptr[idx_width_lp-1:0];
  assign wr_idx = wr_ptr[idx_width_lp-1:0];

  // Same index with differing wrap bits means the writer has lapped the
  // reader by exactly els_p entries.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_idx == wr_idx) && (rd_ptr[ptr_width_lp-1] != wr_ptr[ptr_width_lp-1]);

  // Occupancy is the modular pointer difference; with the wrap bit it spans
  // 0..els_p without ambiguity.
  assign used_cnt = wr_ptr - rd_ptr;
  assign count_o  = count_width_lp'(used_cnt);

  // Both handshake hints come from registered pointers only, so there is no
  // path from deq_yumi_i into enq_ready_o.
  assign enq_ready_o   = ~full;
  assign almost_full_o = (ptr_width_lp'(els_p) - used_cnt) <= ptr_width_lp'(almost_full_slack_p);

  assign head_pkt = mem_q[rd_idx];

`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming packet straight to the head.
  assign bypass_v       = empty & enq_v_i & ~flush_i;
  assign bypass_consume = bypass_v & deq_yumi_i;
  assign deq_v_o        = ~empty | bypass_v;
  assign deq_pkt        = bypass_v ? enq_pkt : head_pkt;
`else
  assign bypass_v       = 1'b0;
  assign bypass_consume = 1'b0;
  assign deq_v_o        = ~empty;
  assign deq_pkt        = head_pkt;
`endif

  assign deq_pc_o              = deq_pkt.pc;
  assign deq_instr_o           = deq_pkt.instr;
  assign deq_br_metadata_fwd_o = deq_pkt.br_metadata_fwd;
  assign deq_exception_v_o     = deq_pkt.exception_v;

  // Illegal handshakes (enq while full, yumi while empty) are masked here so
  // hardware simply ignores them. A bypassed packet that is consumed in the
  // same cycle never touches storage or the pointers.
  assign wr_inc = enq_v_i & ~full & ~flush_i & ~bypass_consume;
  assign rd_inc = deq_yumi_i & ~empty & ~flush_i;

  bp_fe_fetch_queue_ptr #(
    .els_p (els_p)
  ) u_wr_ptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (wr_inc),
    .clr_i   (flush_i),
    .ptr_o   (wr_ptr)
  );

  bp_fe_fetch_queue_ptr #(
    .els_p (els_p)
  ) u_rd_ptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (rd_inc),
    .clr_i   (flush_i),
    .ptr_o   (rd_ptr)
  );

  // Storage is intentionally not reset; deq_* is don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (wr_inc) begin
      mem_q[wr_idx] <= enq_pkt;
    end
  end

`ifndef SYNTHESIS
  yumi_without_valid_a : assert property (
    @(posedge clk_i) disable iff (reset_i) deq_yumi_i |-> deq_v_o);

  enq_without_ready_a : assert property (
    @(posedge clk_i) disable iff (reset_i) enq_v_i |-> enq_ready_o);
`endif

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// tb_bp_fe_fetch_queue: directed scenarios followed by randomized traffic,
// checked every cycle against a queue-based model of the fetch queue.
// Honours BP_FE_FETCH_QUEUE_BYPASS_EN when it is defined for the build.

module tb_bp_fe_fetch_queue;
  import bp_fe_pkg::*;

  localparam int VW    = bp_vaddr_width(e_bp_default_cfg);
  localparam int BW    = bp_br_metadata_fwd_width(e_bp_default_cfg);
  localparam int IW    = fetch_instr_width_lp;
  localparam int ELS   = 4;
  localparam int SLACK = 2;
  localparam int CW    = $clog2(ELS + 1);
  localparam int PKTW  = VW + IW + BW + 1;

`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset_i, flush_i;
  logic          enq_v_i, enq_ready_o;
  logic [VW-1:0] enq_pc_i;
  logic [IW-1:0] enq_instr_i;
  logic [BW-1:0] enq_br_metadata_fwd_i;
  logic          enq_exception_v_i;
  logic          deq_v_o, deq_yumi_i;
  logic [VW-1:0] deq_pc_o;
  logic [IW-1:0] deq_instr_o;
  logic [BW-1:0] deq_br_metadata_fwd_o;
  logic          deq_exception_v_o;
  logic          almost_full_o;
  logic [CW-1:0] count_o;

  bp_fe_fetch_queue #(
    .bp_params_p         (e_bp_default_cfg),
    .els_p               (ELS),
    .almost_full_slack_p (SLACK)
  ) dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .flush_i               (flush_i),
    .enq_v_i               (enq_v_i),
    .enq_ready_o           (enq_ready_o),
    .enq_pc_i              (enq_pc_i),
    .enq_instr_i           (enq_instr_i),
    .enq_br_metadata_fwd_i (enq_br_metadata_fwd_i),
    .enq_exception_v_i     (enq_exception_v_i),
    .deq_v_o               (deq_v_o),
    .deq_yumi_i            (deq_yumi_i),
    .deq_pc_o              (deq_pc_o),
    .deq_instr_o           (deq_instr_o),
    .deq_br_metadata_fwd_o (deq_br_metadata_fwd_o),
    .deq_exception_v_o     (deq_exception_v_o),
    .almost_full_o         (almost_full_o),
    .count_o               (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  // Model: the queue contents in FIFO order, each as {pc, instr, md, exc}.
  logic [PKTW-1:0] mq [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKTW-1:0] enqPacked();
    return {enq_pc_i, enq_instr_i, enq_br_metadata_fwd_i, enq_exception_v_i};
  endfunction

  task automatic applyStimulus(input logic ev, input logic [VW-1:0] pc, input logic yumi,
                               input logic fl, input logic rst);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    enq_v_i               = ev;
    enq_pc_i              = pc;
    enq_instr_i           = $urandom();
    enq_br_metadata_fwd_i = r[BW-1:0];
    enq_exception_v_i     = r[63];
    deq_yumi_i            = yumi;
    flush_i               = fl;
    reset_i               = rst;
  endtask

  // Advance the model with the inputs present at this clock edge.
  task automatic modelUpdate();
    int sz;
    bit byp;
    if (reset_i || flush_i) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      byp = BYP && (sz == 0) && enq_v_i;
      if (!(byp && deq_yumi_i)) begin
        if (deq_yumi_i && sz > 0) void'(mq.pop_front());
        if (enq_v_i && sz < ELS) mq.push_back(enqPacked());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  logic [PKTW-1:0] expHead;
  bit              expV;
  always @(negedge clk) begin
    if (checkEn && !reset_i) begin
      expV = (mq.size() > 0) || (BYP && enq_v_i && !flush_i);
      checkOutput("deq_v", 64'(deq_v_o), 64'(expV));
      if (expV) begin
        expHead = (mq.size() > 0) ? mq[0] : enqPacked();
        checkOutput("deq_pc",    64'(deq_pc_o),              64'(expHead[PKTW-1 -: VW]));
        checkOutput("deq_instr", 64'(deq_instr_o),           64'(expHead[BW+IW : BW+1]));
        checkOutput("deq_md",    64'(deq_br_metadata_fwd_o), 64'(expHead[BW:1]));
        checkOutput("deq_exc",   64'(deq_exception_v_o),     64'(expHead[0]));
      end
      checkOutput("count",       64'(count_o),       64'(mq.size()));
      checkOutput("enq_ready",   64'(enq_ready_o),   64'(mq.size() < ELS));
      checkOutput("almost_full", 64'(almost_full_o), 64'((ELS - mq.size()) <= SLACK));
    end
  end

  initial begin
    bit ev, yumi, fl, canYumi;
    logic [63:0] r;

    // Scenario 1: reset, then one enqueue is visible the next cycle.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    checkEn = 1'b1;
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_deq_v", 64'(deq_v_o), 64'd0);
    checkOutput("rst_ready", 64'(enq_ready_o), 64'd1);
    checkOutput("rst_af",    64'(almost_full_o), 64'd0);
    applyStimulus(1'b1, VW'(64'h8000_0000), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("s1_deq_v", 64'(deq_v_o), 64'd1);
    checkOutput("s1_pc",    64'(deq_pc_o), 64'h8000_0000);
    checkOutput("s1_count", 64'(count_o), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();

    // Scenario 2: fill to full, then drain in FIFO order.
    for (int i = 0; i < ELS; i++) begin
      applyStimulus(1'b1, VW'(64'h1000 + 64'(4 * i)), 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      if (i == 0) checkOutput("s2_af_at1", 64'(almost_full_o), 64'd0);
      if (i == 1) checkOutput("s2_af_at2", 64'(almost_full_o), 64'd1);
    end
    checkOutput("s2_count_full", 64'(count_o), 64'd4);
    checkOutput("s2_ready_full", 64'(enq_ready_o), 64'd0);
    checkOutput("s2_af_full",    64'(almost_full_o), 64'd1);
    for (int i = 0; i < ELS; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("s2_drain_pc", 64'(deq_pc_o), 64'h1000 + 64'(4 * i));
      tick();
    end
    idle();
    checkOutput("s2_empty_v", 64'(deq_v_o), 64'd0);

    // Scenario 3: one-entry prefill, then streaming enq+deq across wraps.
    applyStimulus(1'b1, VW'(64'h3000), 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, VW'(64'h3004 + 64'(4 * i)), 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("s3_pc", 64'(deq_pc_o), 64'h3000 + 64'(4 * i));
      tick();
      checkOutput("s3_count", 64'(count_o), 64'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();

    // Scenario 4: flush with a same-cycle enqueue drops everything.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, VW'(64'h4000 + 64'(4 * i)), 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, VW'(64'h100), 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("s4_count", 64'(count_o), 64'd0);
    checkOutput("s4_deq_v", 64'(deq_v_o), 64'd0);
    tick();
    tick();

    // Scenario 5: mid-operation reset.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, VW'(64'h5000 + 64'(4 * i)), 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("s5_count", 64'(count_o), 64'd0);
    checkOutput("s5_ready", 64'(enq_ready_o), 64'd1);
    checkOutput("s5_deq_v", 64'(deq_v_o), 64'd0);

    // Scenario 6: enqueue into an empty queue, yumi only if bypass makes it legal.
    applyStimulus(1'b1, VW'(64'h200), BYP, 1'b0, 1'b0);
    #1;
    checkOutput("s6_same_v", 64'(deq_v_o), 64'(BYP));
    if (BYP) checkOutput("s6_same_pc", 64'(deq_pc_o), 64'h200);
    tick();
    idle();
    if (BYP) begin
      checkOutput("s6_next_count", 64'(count_o), 64'd0);
    end else begin
      checkOutput("s6_next_v",     64'(deq_v_o), 64'd1);
      checkOutput("s6_next_pc",    64'(deq_pc_o), 64'h200);
      checkOutput("s6_next_count", 64'(count_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
    end

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      fl      = ($urandom_range(0, 31) == 0);
      ev      = (mq.size() < ELS) && ($urandom_range(0, 9) < 6);
      canYumi = (mq.size() > 0) || (BYP && ev && !fl);
      yumi    = canYumi && ($urandom_range(0, 1) == 1);
      r       = {$urandom(), $urandom()};
      applyStimulus(ev, r[VW-1:0], yumi, fl, 1'b0);
      tick();
    end

    idle();
    checkEn = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
